sram_port_ctrl: RTL and testbench

Fabric-facing access controller placed directly upstream of the 1024x32 IHP SRAM wrapper. It converts a valid/ready request stream (read or byte-masked write) into the wrapper's MEN/WEN/REN/ADDR/DIN/BM strobes. Read data is returned through a 2-entry response FIFO with backpressure. After reset, an optional sweep initialises every word to a fixed value before requests are accepted.

---
 rtl/sram_port_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sram_port_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl.sv
// Valid/ready front end for the 1024x32 SRAM wrapper: strobe generation,
// post-reset init sweep, and a 2-entry read-response FIFO with backpressure.

module sram_port_ctrl_lane #(
  parameter int VEC_W = 8
) (
  input  logic             init,
  input  logic             wr,
  input  logic             be,
  input  logic [VEC_W-1:0] wdata,
  input  logic [VEC_W-1:0] iword,
  output logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] bm
);
  always_comb begin
    din = '0;
    bm  = '0;
    if (init) begin
      din = iword;
      bm  = '1;
    end else if (wr) begin
      din = wdata;
      bm  = be ? '1 : '0;
    end
  end
endmodule

module sram_port_ctrl #(
  parameter int          ADDR_W    = 10,
  parameter bit          INIT_EN   = 1'b1,
  parameter logic [31:0] INIT_WORD = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] ADDR,
  output logic [31:0]       DIN,
  output logic [31:0]       BM,
  output logic              MEN,
  output logic              WEN,
  output logic              REN,
  input  logic [31:0]       DOUT
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } req_t;

  req_t              req;
  logic [1:0]        state;
  logic [ADDR_W-1:0] icnt;
  logic              init_act, run;
  logic              acc, rd_acc, wr_acc;
  logic              rd_pend, push, pop;
  logic [1:0]        cnt;
  logic [2:0]        occ;
  logic              wp, rp;
  logic [1:0][31:0]  fifo;

  logic [NUM_LANES-1:0][VEC_W-1:0] din_l, bm_l;

  assign req = '{we: req_we, addr: req_addr, be: req_be, wdata: req_wdata};

  // ---------------- state machine and init sweep ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_START;
      icnt  <= '0;
    end else begin
      unique case (state)
        ST_START: state <= INIT_EN ? ST_INIT : ST_RUN;
        ST_INIT: begin
          icnt <= icnt + 1'b1;
          if (&icnt) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign init_act  = (state == ST_INIT);
  assign run       = (state == ST_RUN);
  assign init_done = run;

  // Outstanding reads = FIFO entries plus the read in flight in the macro;
  // a same-cycle pop frees a slot, so it is credited before comparing.
  assign pop       = rsp_valid && rsp_ready;
  assign occ       = {1'b0, cnt} + {2'b0, rd_pend};
  assign req_ready = run && (occ < (3'd2 + {2'b0, pop}));

  assign acc    = req_valid && req_ready;
  assign rd_acc = acc && !req.we;
  assign wr_acc = acc && req.we;

  // ---------------- wrapper strobes ----------------
  assign MEN  = init_act || acc;
  assign WEN  = init_act || wr_acc;
  assign REN  = rd_acc;
  assign ADDR = init_act ? icnt : (acc ? req.addr : '0);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sram_port_ctrl_lane #(.VEC_W(VEC_W)) u_lane (
      .init  (init_act),
      .wr    (wr_acc),
      .be    (req.be[i]),
      .wdata (req.wdata[i*VEC_W +: VEC_W]),
      .iword (INIT_WORD[i*VEC_W +: VEC_W]),
      .din   (din_l[i]),
      .bm    (bm_l[i])
    );
  end

  assign DIN = din_l;
  assign BM  = bm_l;

  // ---------------- read pipeline and response FIFO ----------------
  // DOUT is valid the cycle after a read strobe, so capture it on the next edge.
  assign push = rd_pend;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_pend <= 1'b0;
      cnt     <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      fifo    <= '0;
    end else begin
      rd_pend <= rd_acc;
      if (push) begin
        fifo[wp] <= DOUT;
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rsp_valid = (cnt != 2'd0);
  assign rsp_rdata = fifo[rp];

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: behavioural SRAM on the wrapper strobes plus a
// request-level reference memory and expected-response queue.

module tb_sram_port_ctrl;
  localparam int          AW = 10;
  localparam logic [31:0] IW = 32'hA5A5_A5A5;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [3:0]    req_be = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready, rsp_valid, init_done, MEN, WEN, REN;
  logic [31:0]   rsp_rdata, DIN, BM;
  logic [AW-1:0] ADDR;
  logic [31:0]   dout = '0;

  sram_port_ctrl #(.ADDR_W(AW), .INIT_EN(1'b1), .INIT_WORD(IW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .ADDR(ADDR), .DIN(DIN), .BM(BM),
    .MEN(MEN), .WEN(WEN), .REN(REN), .DOUT(dout)
  );

  always #5 CLK = ~CLK;

  // Wrapper model: synchronous write with bit mask, registered read data.
  logic [31:0] sram [1024];
  always @(posedge CLK) begin
    if (MEN && WEN) sram[ADDR] <= (sram[ADDR] & ~BM) | (DIN & BM);
    if (MEN && REN) dout <= sram[ADDR];
  end

  int tests = 0, fails = 0;
  int cyc = 0, acc_cnt = 0, rd_tot = 0, pop_tot = 0, rdy_err = 0;
  bit chk_rdy = 0;
  logic last_rdy, last_acc;
  logic [31:0] last_bm;
  logic [31:0] ref_mem [1024];
  logic [31:0] got[$], expq[$];
  int pop_cyc[$];

  // One request cycle: observe at the negedge, update the reference model.
  task automatic step();
    logic p;
    @(negedge CLK);
    p = rsp_valid && rsp_ready;
    if (chk_rdy && (req_ready !== ((rd_tot - pop_tot - int'(p)) < 2))) rdy_err++;
    last_rdy = req_ready;
    last_bm  = BM;
    last_acc = req_valid && req_ready;
    if (last_acc) begin
      acc_cnt++;
      if (req_we) begin
        for (int b = 0; b < 4; b++)
          if (req_be[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
      end else begin
        expq.push_back(ref_mem[req_addr]);
        rd_tot++;
      end
    end
    if (p) begin
      got.push_back(rsp_rdata);
      pop_cyc.push_back(cyc);
      pop_tot++;
    end
    @(posedge CLK); #1;
    cyc++;
  endtask

  task automatic set_req(input logic v, input logic we, input int a, input logic [3:0] be,
                         input logic [31:0] d);
    req_valid = v; req_we = we; req_addr = AW'(a); req_be = be; req_wdata = d;
  endtask

  task automatic drain();
    set_req(0, 0, 0, 4'h0, 32'h0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic clear_q();
    got.delete(); expq.delete(); pop_cyc.delete();
  endtask

  // Releases reset and counts sweep writes until init_done or stop_at.
  task automatic run_sweep(input int stop_at, output int wen_cnt, output int bad,
                           output int done_edge);
    bit stop;
    wen_cnt = 0; bad = 0; done_edge = 0; stop = 0;
    RST_N = 1'b1;
    for (int e = 1; e <= 1200 && !stop; e++) begin
      @(posedge CLK); #1;
      if (MEN && WEN) begin
        if (ADDR !== AW'(wen_cnt) || DIN !== IW || BM !== 32'hFFFF_FFFF || REN !== 1'b0) bad++;
        if (wen_cnt == stop_at) stop = 1;
        wen_cnt++;
      end
      if (init_done === 1'b1) begin
        done_edge = e;
        stop = 1;
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #1;
    tests++;
    if ({req_ready, rsp_valid, init_done, MEN, WEN, REN} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 000000", {req_ready, rsp_valid, init_done, MEN, WEN, REN});
    end
    tests++;
    if (rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata: got %h want 0", rsp_rdata);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_init_sweep();
    int n, bad, de;
    run_sweep(-1, n, bad, de);
    for (int i = 0; i < 1024; i++) ref_mem[i] = IW;
    tests++;
    if (n !== 1024) begin fails++; $display("FAIL sweep_count: got %0d want 1024", n); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL sweep_strobes: %0d bad writes want 0", bad); end
    tests++;
    if (de !== 1025) begin fails++; $display("FAIL sweep_done_edge: got %0d want 1025", de); end
    clear_q();
    rsp_ready = 1'b1;
    set_req(1, 0, 10'h3FF, 4'h0, 32'h0);
    step();
    drain();
    tests++;
    if (got.size() !== 1 || got[0] !== IW) begin
      fails++;
      $display("FAIL sweep_read_3ff: got %0d rsp %h want 1 rsp %h", got.size(),
               got.size() ? got[0] : 32'h0, IW);
    end
  endtask

  task automatic test_byte_mask();
    logic [31:0] bm2;
    clear_q();
    set_req(1, 1, 10'h010, 4'hF, 32'h1122_3344); step();
    set_req(1, 1, 10'h010, 4'b0101, 32'hFFFF_FFFF); step();
    bm2 = last_bm;
    set_req(1, 0, 10'h010, 4'hF, 32'h0); step();
    drain();
    tests++;
    if (bm2 !== 32'h00FF_00FF) begin fails++; $display("FAIL byte_mask_bm: got %h want 00ff00ff", bm2); end
    tests++;
    if (got.size() !== 1 || got[0] !== 32'h11FF_33FF) begin
      fails++;
      $display("FAIL byte_mask_data: got %h want 11ff33ff", got.size() ? got[0] : 32'hx);
    end
  endtask

  task automatic test_back_to_back();
    int c0, acc0, bad;
    clear_q();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin set_req(1, 1, i, 4'hF, 32'(i*3)); step(); end
    acc0 = acc_cnt;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin set_req(1, 0, i, 4'h0, 32'h0); step(); end
    tests++;
    if (acc_cnt - acc0 !== 8) begin fails++; $display("FAIL b2b_accepts: got %0d want 8", acc_cnt - acc0); end
    drain();
    bad = 0;
    tests++;
    if (got.size() !== 8) begin
      fails++;
      $display("FAIL b2b_count: got %0d want 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++)
        if (got[i] !== 32'(i*3) || pop_cyc[i] !== c0 + 2 + i) bad++;
      tests++;
      if (bad !== 0) begin
        fails++;
        $display("FAIL b2b_data_timing: %0d bad responses (first %h @%0d, want 0 @%0d)",
                 bad, got[0], pop_cyc[0], c0 + 2);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc0;
    logic rdy_full, rdy_pop;
    clear_q();
    rsp_ready = 1'b0;
    acc0 = acc_cnt;
    for (int i = 0; i < 6; i++) begin set_req(1, 0, i, 4'h0, 32'h0); step(); end
    rdy_full = last_rdy;
    tests++;
    if (acc_cnt - acc0 !== 2) begin fails++; $display("FAIL bp_accepts: got %0d want 2", acc_cnt - acc0); end
    tests++;
    if (rdy_full !== 1'b0) begin fails++; $display("FAIL bp_ready_full: got %b want 0", rdy_full); end
    rsp_ready = 1'b1;
    set_req(1, 0, 6, 4'h0, 32'h0);
    step();
    rdy_pop = last_rdy;
    tests++;
    if (rdy_pop !== 1'b1) begin fails++; $display("FAIL bp_ready_pop_credit: got %b want 1", rdy_pop); end
    drain();
    tests++;
    if (got.size() !== 3 || got[0] !== 32'd0 || got[1] !== 32'd3 || got[2] !== 32'd18) begin
      fails++;
      $display("FAIL bp_order: got %0d entries first %h want 3 entries 0,3,18", got.size(),
               got.size() ? got[0] : 32'hx);
    end
  endtask

  task automatic test_raw();
    clear_q();
    rsp_ready = 1'b1;
    set_req(1, 1, 10'h2AA, 4'hF, 32'hDEAD_BEEF); step();
    set_req(1, 0, 10'h2AA, 4'h0, 32'h0); step();
    drain();
    tests++;
    if (got.size() !== 1 || got[0] !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL raw: got %h want deadbeef", got.size() ? got[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    int bad;
    clear_q();
    rdy_err = 0;
    chk_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      set_req($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
              4'($urandom), $urandom);
      step();
    end
    drain();
    chk_rdy = 0;
    tests++;
    if (rdy_err !== 0) begin fails++; $display("FAIL rand_ready: %0d cycles wrong want 0", rdy_err); end
    bad = 0;
    tests++;
    if (got.size() !== expq.size()) begin
      fails++;
      $display("FAIL rand_count: got %0d responses want %0d", got.size(), expq.size());
    end else begin
      for (int i = 0; i < got.size(); i++) if (got[i] !== expq[i]) bad++;
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL rand_data: %0d mismatched responses want 0", bad); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n, bad, de;
    set_req(0, 0, 0, 4'h0, 32'h0);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    run_sweep(500, n, bad, de);
    tests++;
    if (n !== 501 || WEN !== 1'b1) begin
      fails++;
      $display("FAIL midsweep_reach: got %0d writes WEN %b want 501 WEN 1", n, WEN);
    end
    RST_N = 1'b0;
    #1;
    tests++;
    if ({MEN, WEN, REN, req_ready, init_done} !== 5'b0) begin
      fails++;
      $display("FAIL midsweep_strobes: got %b want 00000", {MEN, WEN, REN, req_ready, init_done});
    end
    #3;
    run_sweep(-1, n, bad, de);
    for (int i = 0; i < 1024; i++) ref_mem[i] = IW;
    tests++;
    if (n !== 1024 || bad !== 0 || de !== 1025) begin
      fails++;
      $display("FAIL midsweep_restart: got %0d writes %0d bad done@%0d want 1024 0 1025", n, bad, de);
    end
    clear_q();
    set_req(1, 0, 10'h010, 4'h0, 32'h0); step();
    drain();
    tests++;
    if (got.size() !== 1 || got[0] !== IW) begin
      fails++;
      $display("FAIL midsweep_read: got %h want %h", got.size() ? got[0] : 32'hx, IW);
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_byte_mask();
    test_back_to_back();
    test_backpressure();
    test_raw();
    test_random();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
